// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: owns the CP0 register file, the Count/Compare timer and the
// hardware-interrupt sampler, and prioritises and commits M-stage exceptions.
module cp0_exc_unit #(
  parameter int unsigned NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  validM,
  input  logic                  stallM,
  input  logic [31:0]           pcM,
  input  logic                  in_dslotM,
  input  logic [31:0]           bad_addrM,
  input  logic                  adel_ifM,
  input  logic                  adel_dM,
  input  logic                  adesM,
  input  logic                  syscallM,
  input  logic                  breakM,
  input  logic                  riM,
  input  logic                  ovM,
  input  logic                  eretM,
  input  logic                  cp0_weM,
  input  logic [4:0]            cp0_waddrM,
  input  logic [31:0]           cp0_wdataM,
  input  logic [4:0]            cp0_raddr,
  output logic [31:0]           cp0_rdata,
  output logic [31:0]           excepttypeM,
  output logic [31:0]           newpcM,
  output logic                  flushM,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o
);

  localparam int unsigned      DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);
  localparam logic [31:0]      STATUS_WMASK = 32'h0000_FF03;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_ADEL    = 32'h4;
  localparam logic [31:0] EXC_ADES    = 32'h5;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_BREAK   = 32'h9;
  localparam logic [31:0] EXC_RI      = 32'hA;
  localparam logic [31:0] EXC_OV      = 32'hC;
  localparam logic [31:0] EXC_ERET    = 32'hE;

  typedef enum logic [1:0] {
    BAD_NONE,
    BAD_PC,
    BAD_DATA
  } bad_sel_e;

  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           status_q, status_d;
  logic [31:0]           epc_q, epc_d;
  logic                  bd_q, bd_d;
  logic                  ti_q, ti_d;
  logic [4:0]            exccode_q, exccode_d;
  logic [1:0]            sw_ip_q, sw_ip_d;
  logic [NUM_HW_INT-1:0] hw_ip_q;
  logic [DIV_W-1:0]      div_q, div_d;

  logic [5:0]  hw_ip_ext;
  logic [7:0]  ip;
  logic [31:0] cause_val;

  logic        mtc0_hit, wr_status, wr_cause, wr_epc;
  logic [31:0] status_wr;
  logic [7:0]  im_byp, ip_byp;
  logic        ie_byp, exl_byp;
  logic        int_pending;
  logic [31:0] epc_byp;

  logic [31:0] exc_type;
  logic [4:0]  exc_code;
  bad_sel_e    bad_sel;
  logic        is_eret;
  logic        exc_commit, mtc0_commit;

  // Unused hardware lines read as zero; line 5 shares IP[7] with the timer.
  always_comb begin
    hw_ip_ext = '0;
    hw_ip_ext[NUM_HW_INT-1:0] = hw_ip_q;
  end

  assign ip        = {hw_ip_ext[5] | ti_q, hw_ip_ext[4:0], sw_ip_q};
  assign cause_val = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

  assign mtc0_hit  = cp0_weM && validM;
  assign wr_status = mtc0_hit && (cp0_waddrM == REG_STATUS);
  assign wr_cause  = mtc0_hit && (cp0_waddrM == REG_CAUSE);
  assign wr_epc    = mtc0_hit && (cp0_waddrM == REG_EPC);
  assign status_wr = (status_q & ~STATUS_WMASK) | (cp0_wdataM & STATUS_WMASK);

  // Interrupt check sees an MTC0 to Status/Cause in the same cycle.
  assign im_byp  = wr_status ? cp0_wdataM[15:8] : status_q[15:8];
  assign ie_byp  = wr_status ? cp0_wdataM[0]    : status_q[0];
  assign exl_byp = wr_status ? cp0_wdataM[1]    : status_q[1];
  assign ip_byp  = {ip[7:2], wr_cause ? cp0_wdataM[9:8] : sw_ip_q};

  assign int_pending = (|(ip_byp & im_byp)) && ie_byp && !exl_byp;
  assign epc_byp     = wr_epc ? cp0_wdataM : epc_q;

  always_comb begin
    exc_type = '0;
    exc_code = '0;
    bad_sel  = BAD_NONE;
    if (!rst && validM) begin
      if (int_pending) begin
        exc_type = EXC_INT;
        exc_code = 5'd0;
      end else if (adel_ifM) begin
        exc_type = EXC_ADEL;
        exc_code = 5'd4;
        bad_sel  = BAD_PC;
      end else if (riM) begin
        exc_type = EXC_RI;
        exc_code = 5'd10;
      end else if (ovM) begin
        exc_type = EXC_OV;
        exc_code = 5'd12;
      end else if (syscallM) begin
        exc_type = EXC_SYSCALL;
        exc_code = 5'd8;
      end else if (breakM) begin
        exc_type = EXC_BREAK;
        exc_code = 5'd9;
      end else if (adel_dM) begin
        exc_type = EXC_ADEL;
        exc_code = 5'd4;
        bad_sel  = BAD_DATA;
      end else if (adesM) begin
        exc_type = EXC_ADES;
        exc_code = 5'd5;
        bad_sel  = BAD_DATA;
      end else if (eretM) begin
        exc_type = EXC_ERET;
      end
    end
  end

  assign is_eret     = (exc_type == EXC_ERET);
  assign excepttypeM = exc_type;
  assign flushM      = (exc_type != '0);
  assign newpcM      = is_eret ? epc_byp : EXC_VECTOR;

  assign exc_commit  = (exc_type != '0) && !stallM;
  assign mtc0_commit = mtc0_hit && !stallM && (exc_type == '0);

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    status_d   = status_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    exccode_d  = exccode_q;
    sw_ip_d    = sw_ip_q;
    div_d      = div_q;

    // Timer runs regardless of stalls.
    if (mtc0_commit && (cp0_waddrM == REG_COUNT)) begin
      count_d = cp0_wdataM;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      div_d   = '0;
      count_d = count_q + 32'd1;
    end else begin
      div_d   = div_q + DIV_W'(1);
    end

    if ((count_q == compare_q) && (compare_q != '0))
      ti_d = 1'b1;
    if (mtc0_commit && (cp0_waddrM == REG_COMPARE))
      ti_d = 1'b0;

    if (exc_commit) begin
      if (is_eret) begin
        status_d[1] = 1'b0;
      end else begin
        // A nested exception keeps the original return point.
        if (!status_q[1]) begin
          epc_d = in_dslotM ? (pcM - 32'd4) : pcM;
          bd_d  = in_dslotM;
        end
        exccode_d   = exc_code;
        status_d[1] = 1'b1;
        case (bad_sel)
          BAD_PC:   badvaddr_d = pcM;
          BAD_DATA: badvaddr_d = bad_addrM;
          default:  badvaddr_d = badvaddr_q;
        endcase
      end
    end else if (mtc0_commit) begin
      case (cp0_waddrM)
        REG_STATUS:  status_d  = status_wr;
        REG_CAUSE:   sw_ip_d   = cp0_wdataM[9:8];
        REG_EPC:     epc_d     = cp0_wdataM;
        REG_COMPARE: compare_d = cp0_wdataM;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exccode_q  <= '0;
      sw_ip_q    <= '0;
      hw_ip_q    <= '0;
      div_q      <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exccode_q  <= exccode_d;
      sw_ip_q    <= sw_ip_d;
      hw_ip_q    <= int_i;
      div_q      <= div_d;
    end
  end

  always_comb begin
    case (cp0_raddr)
      REG_BADVADDR: cp0_rdata = badvaddr_q;
      REG_COUNT:    cp0_rdata = count_q;
      REG_COMPARE:  cp0_rdata = compare_q;
      REG_STATUS:   cp0_rdata = status_q;
      REG_CAUSE:    cp0_rdata = cause_val;
      REG_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = '0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_val;
  assign epc_o       = epc_q;
  assign timer_int_o = ti_q;

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
Parametrised successor to the combinational exception decoder. Owns the CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC), the timer interrupt and the hardware-interrupt sampler. It prioritises memory-stage exceptions, commits exception state on the clock edge, and drives flush and redirect PC to the pipeline. It sits beside the M stage, with a single-cycle MFC0 read port for the E/M stage.

Parameters:
NUM_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2 +: NUM_HW_INT]
EXC_VECTOR, 32'hBFC0_0380, redirect PC for all exceptions except eret
COUNT_DIV, 2, clock cycles per Count increment (>=1)
STATUS_RST, 32'h0040_0000, reset value of Status (BEV=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
int_i  in  NUM_HW_INT  hardware interrupt lines, level-sensitive, asynchronous to the pipeline
validM  in  1  M-stage instruction is real (not bubble)
stallM  in  1  M stage held this cycle
pcM  in  32  M-stage instruction PC
in_dslotM  in  1  M-stage instruction is in a branch delay slot
bad_addrM  in  32  data address of M-stage load/store
adel_ifM, adel_dM, adesM, syscallM, breakM, riM, ovM, eretM  in  1 each  exception flags
cp0_weM  in  1  MTC0 write enable
cp0_waddrM  in  5  MTC0 register number
cp0_wdataM  in  32  MTC0 data
cp0_raddr  in  5  MFC0 register number
cp0_rdata  out  32  MFC0 data (combinational)
excepttypeM  out  32  encoded exception type, 0 = none
newpcM  out  32  redirect target
flushM  out  1  pipeline flush, valid when excepttypeM != 0
status_o, cause_o, epc_o  out  32 each  architectural CP0 values
timer_int_o  out  1  Cause.TI

Behaviour:
- Reset (rst=1 at the edge): BadVAddr=0, Count=0, Compare=0, Status=STATUS_RST, Cause=0, EPC=0, divider=0, interrupt sampler=0. Combinational outputs follow the reset register values; excepttypeM=0 and flushM=0 while rst=1.
- Interrupt sampler: int_i is registered every cycle into Cause.IP[2 +: NUM_HW_INT]. Unused IP bits read 0. IP[7] is the OR of the sampled line 5 (if present) and TI. IP[1:0] are written only by MTC0.
- Timer:
  - Divider counts 0..COUNT_DIV-1; Count increments when the divider wraps. Count wraps from FFFF_FFFF to 0.
  - TI is set on the cycle after Count==Compare, provided Compare != 0.
  - An MTC0 write to Compare clears TI. An MTC0 write to Count loads Count and resets the divider.
- Pending interrupt: (Cause.IP & Status.IM) != 0 && Status.IE && !Status.EXL. It is evaluated with the registered values, plus a same-cycle bypass of cp0_wdataM when MTC0 writes Status or Cause.
- Priority, evaluated only when validM=1. excepttypeM codes and Cause.ExcCode values:
  - int: 1, ExcCode 0
  - adel_ifM: 4, ExcCode 4
  - riM: A, ExcCode 10
  - ovM: C, ExcCode 12
  - syscallM: 8, ExcCode 8
  - breakM: 9, ExcCode 9
  - adel_dM: 4, ExcCode 4
  - adesM: 5, ExcCode 5
  - eretM: E, no ExcCode
- newpcM = EPC (bypassed if MTC0 writes EPC this cycle) when excepttypeM=E; otherwise EXC_VECTOR. flushM = (excepttypeM != 0).
- Commit, at the edge when excepttypeM != 0 and stallM=0:
  - Non-eret exception: EPC = in_dslotM ? pcM-4 : pcM, Cause.BD = in_dslotM, Cause.ExcCode set, Status.EXL = 1.
  - BadVAddr = pcM for adel_if; BadVAddr = bad_addrM for adel_d/ades.
  - If Status.EXL was already 1, EPC and BD are not updated; ExcCode still is.
  - eret: Status.EXL = 0 only.
- MTC0 commits at the edge when cp0_weM && validM && !stallM && excepttypeM==0. An exception in the same cycle suppresses the write.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8] only.
  - EPC, Compare, Count: full 32 bits.
  - BadVAddr and all other registers are read-only.
- A stall holds all CP0 state except Count, divider, TI and the sampler.
- cp0_rdata returns the register for addresses 8/9/11/12/13/14, else 0. It does not reflect a same-cycle write.
- Reset mid-exception: register state returns to reset values at that edge, and no commit occurs.

Test Plan:
- Reset, then MFC0 12 -> 32'h0040_0000. MFC0 13 and 14 -> 0. excepttypeM=0.
- syscallM=1, pcM=32'hBFC0_1000, in_dslotM=1 -> excepttypeM=8, newpcM=BFC0_0380, flushM=1; next cycle EPC=BFC0_0FFC, Cause.BD=1, ExcCode=8, EXL=1. Then eretM=1 -> newpcM=BFC0_0FFC; next cycle EXL=0.
- riM and ovM and adesM together -> excepttypeM=A. adel_dM=1 with bad_addrM=32'h8000_0003 -> excepttypeM=4, BadVAddr=8000_0003.
- MTC0 Compare=10, Count=0, COUNT_DIV=2, Status IM7=1, IE=1 -> TI rises after Count reaches 10 (about 21 cycles) and excepttypeM=1 on a valid instruction. MTC0 Compare clears TI.
- int_i[0] pulses with IM2=1 while EXL=1 -> no interrupt taken. After eret clears EXL -> excepttypeM=1.
- MTC0 EPC with eretM in the same cycle -> newpcM equals the written value. MTC0 Status together with syscallM -> write suppressed, Status shows only EXL=1.
